adder_la_32bit: RTL and testbench
=================================

# adder_la_32bit

Registered 32-bit two-level carry-lookahead adder computing `op1 + op2 + cin` with carry-out. It serves as the datapath adder for ALU and address-generation blocks. Operands are sampled on the clock edge, and results are held in output registers, giving exactly one cycle of latency.

## Interface
Parameters:
- none; the width is fixed at 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `op1`  in  32  operand A, unsigned or two's complement.
- `op2`  in  32  operand B.
- `cin`  in  1  carry-in to bit 0.
- `sum`  out  32  registered `(op1 + op2 + cin) mod 2^32`.
- `cout`  out  1  registered carry-out of bit 31.
- `ovf`  out  1  registered signed overflow; present only with `ADDER_LA_OVF_EN`.

## Operation
- Per-bit signals: propagate `p[i] = op1[i] ^ op2[i]`, generate `g[i] = op1[i] & op2[i]`.
- Level 1: eight 4-bit lookahead groups.
  - Each group produces internal carries `c[k+1] = g[k] | p[k]&c[k]`, expanded in sum-of-products form with no ripple chain.
  - Each group also produces group signals `GP = &p[3:0]` and `GG = g3 | p3g2 | p3p2g1 | p3p2p1g0`.
- Level 2: a lookahead unit over the eight `GP`/`GG` pairs computes the group carry-ins `C4, C8 … C28` and `C32` directly from `cin`. It is implemented as two 4-group lookahead units plus one top-level combine.
- Sum bits: `s[i] = p[i] ^ c[i]`. Carry-out: `cout_next = C32`.
- Overflow: `ovf_next = c[31] ^ C32`, i.e. set when both operands share a sign and the result sign differs.
- Arithmetic is modulo 2^32. No saturation, and no special-casing of operand values.
- The combinational path is purely combinational from inputs to the output-register D pins. No latches.
- The behavioural `+` operator must not be used in the carry network.

## Timing
- Latency is 1 cycle. Inputs are sampled at rising edge N, and `sum`/`cout`/`ovf` reflect them from edge N onward, until edge N+1.
- Throughput is one new operation per cycle. There is no handshake and no stall.
- Reset: while `rst` = 1 at a rising edge, `sum` = 32'h0, `cout` = 0 and `ovf` = 0. Reset overrides any concurrent operands.
- Deassertion: the first edge with `rst` = 0 registers the current inputs normally.
- Reset mid-stream drops the in-flight result. No state survives reset.
- Inputs changing between edges have no effect on outputs until the next edge.
- The output registers are the only sequential elements.

## Configuration
- `ADDER_LA_OVF_EN` defined: the `ovf` port and its register exist, behaving as specified under Operation and Timing.
- `ADDER_LA_OVF_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst` = 1 with op1 = FFFFFFFF, op2 = 1, cin = 1 -> `sum` = 0, `cout` = 0, `ovf` = 0. After deassertion, the next edge yields `sum` = 00000001, `cout` = 1.
- Small values: op1 = 7, op2 = 7, cin = 0 -> `sum` = 0000000E, `cout` = 0. With cin = 1 -> `sum` = 0000000F, `cout` = 0.
- Full carry chain: op1 = F0F0F0F0, op2 = 0F0F0F0F, cin = 1 -> `sum` = 00000000, `cout` = 1, `ovf` = 0. This exercises all group propagates.
- Signed overflow: op1 = 7FFFFFFF, op2 = 00000001, cin = 0 -> `sum` = 80000000, `cout` = 0, `ovf` = 1. Also op1 = 80000000, op2 = 80000000 -> `sum` = 0, `cout` = 1, `ovf` = 1.
- Back-to-back: apply the three vectors from the small-values and full-carry-chain scenarios on consecutive cycles, repeated 10 times -> each result appears exactly one cycle after its inputs, with no bubbles.
- Random: 10k random op1/op2/cin compared against the 33-bit reference `{cout, sum} = op1 + op2 + cin`, including a random `rst` pulse mid-stream.

Source files
------------

// File: rtl/adder_la_32bit.sv
// Registered 32-bit two-level carry-lookahead adder, one cycle latency.
// Define ADDER_LA_OVF_EN to add the registered signed-overflow output ovf.
module adder_la_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
`ifdef ADDER_LA_OVF_EN
  ,
  output logic        ovf
`endif
);

  // Returns {c3, c2, c1} for a 4-wide lookahead block, flat SOP form.
  function automatic logic [2:0] la_carry(
    input logic [3:0] g,
    input logic [2:0] p,
    input logic       ci
  );
    logic c1, c2, c3;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & ci);
    return {c3, c2, c1};
  endfunction

  function automatic logic la_gen(
    input logic [3:0] g,
    input logic [3:1] p
  );
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;
  logic        bg_lo;
  logic        bp_lo;
  logic        bg_hi;
  logic        bp_hi;

  logic [31:0] sum_d;
  logic [31:0] sum_q;
  logic        cout_d;
  logic        cout_q;

  assign p = op1 ^ op2;
  assign g = op1 & op2;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int j = 0; j < 8; j++) begin
      gg[j] = la_gen(g[4*j +: 4], p[4*j+1 +: 3]);
      gp[j] = &p[4*j +: 4];
    end
  end

  // Level 2: two 4-group units joined by one top-level combine.
  always_comb begin
    bg_lo   = la_gen(gg[3:0], gp[3:1]);
    bp_lo   = &gp[3:0];
    bg_hi   = la_gen(gg[7:4], gp[7:5]);
    bp_hi   = &gp[7:4];
    gc      = '0;
    gc[0]   = cin;
    gc[3:1] = la_carry(gg[3:0], gp[2:0], cin);
    gc[4]   = bg_lo | (bp_lo & cin);
    gc[7:5] = la_carry(gg[7:4], gp[6:4], bg_lo | (bp_lo & cin));
    gc[8]   = bg_hi | (bp_hi & bg_lo) | (bp_hi & bp_lo & cin);
  end

  always_comb begin
    c = '0;
    for (int j = 0; j < 8; j++) begin
      c[4*j] = gc[j];
      c[4*j+1 +: 3] = la_carry(g[4*j +: 4], p[4*j +: 3], gc[j]);
    end
  end

  assign sum_d  = p ^ c;
  assign cout_d = gc[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef ADDER_LA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  assign ovf_d = c[31] ^ gc[8];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_la_32bit.sv
// Directed and random bench for adder_la_32bit.
// ovf is checked only when ADDER_LA_OVF_EN is defined.
module tb_adder_la_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
`ifdef ADDER_LA_OVF_EN
  logic        ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  adder_la_32bit dut (
    .clk  (clk),
    .rst  (rst),
    .op1  (op1),
    .op2  (op2),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
`ifdef ADDER_LA_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic ci);
    op1 = a;
    op2 = b;
    cin = ci;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] es,
                     input logic ec, input logic eo);
    n_cmp++;
    assert (sum === es) else begin
      n_err++;
      $error("FAIL %s sum got %h exp %h", tag, sum, es);
    end
    n_cmp++;
    assert (cout === ec) else begin
      n_err++;
      $error("FAIL %s cout got %b exp %b", tag, cout, ec);
    end
`ifdef ADDER_LA_OVF_EN
    n_cmp++;
    assert (ovf === eo) else begin
      n_err++;
      $error("FAIL %s ovf got %b exp %b", tag, ovf, eo);
    end
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic        rc;
  logic [32:0] ref33;
  logic        ref_ovf;

  initial begin
    rst = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    tick();
    chk("reset0", 32'h0, 1'b0, 1'b0);
    tick();
    chk("reset1", 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    tick();
    chk("deassert", 32'h0000_0001, 1'b1, 1'b0);

    drive(32'h7, 32'h7, 1'b0);
    tick();
    chk("small_c0", 32'h0000_000E, 1'b0, 1'b0);

    // Inputs changing mid-cycle must not reach the outputs.
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    #3;
    chk("hold", 32'h0000_000E, 1'b0, 1'b0);

    drive(32'h7, 32'h7, 1'b1);
    tick();
    chk("small_c1", 32'h0000_000F, 1'b0, 1'b0);

    drive(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
    tick();
    chk("chain", 32'h0, 1'b1, 1'b0);

    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    chk("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);

    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    tick();
    chk("ovf_neg", 32'h0, 1'b1, 1'b1);

    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    chk("all_ones", 32'hFFFF_FFFF, 1'b1, 1'b0);

    drive(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    tick();
    chk("half_carry", 32'h0001_0000, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      drive(32'h7, 32'h7, 1'b0);
      tick();
      chk("b2b_a", 32'h0000_000E, 1'b0, 1'b0);
      drive(32'h7, 32'h7, 1'b1);
      tick();
      chk("b2b_b", 32'h0000_000F, 1'b0, 1'b0);
      drive(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1);
      tick();
      chk("b2b_c", 32'h0, 1'b1, 1'b0);
    end

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        rst = 1'b1;
        drive($urandom, $urandom, 1'b1);
        tick();
        chk("rand_rst", 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
      end
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i % 16 == 0) ra = 32'hFFFF_FFFF ^ rb;
      drive(ra, rb, rc);
      ref33   = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      ref_ovf = (ra[31] == rb[31]) && (ref33[31] != ra[31]);
      tick();
      chk("rand", ref33[31:0], ref33[32], ref_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
